// File: rtl/hex_scan.sv
// hex_scan: four-digit multiplexed seven-segment scanner for a 16-bit
// memory-mapped hex display register. Each digit owns a slot of DIV
// cycles whose last GAP cycles have every anode off. A shadow copy of the
// display value is taken once per frame to stop tearing. The block also
// supports leading-zero blanking and a whole-display blink. The anode and
// segment outputs are registered.
module hex_scan #(
    parameter int unsigned DIV          = 50000,
    parameter int unsigned GAP          = 1000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [15:0] hdata,
    input  logic        blank_lz,
    input  logic        blink_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ACTIVE = CW'(DIV - GAP);
    localparam logic [FW-1:0] FCNT_LAST  = FW'(BLINK_FRAMES - 1);

    typedef enum logic {
        PH_OFF = 1'b0,
        PH_ON  = 1'b1
    } phase_e;

    logic [CW-1:0] cnt_q,    cnt_d;
    logic [1:0]    d_q,      d_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [FW-1:0] fcnt_q,   fcnt_d;
    phase_e        phase_q,  phase_d;
    logic [3:0]    an_q,     an_d;
    logic [6:0]    seg_q,    seg_d;
    logic          fd_q,     fd_d;

    logic       tick;
    logic       wrap;
    logic       slot_active;
    logic       show_on;
    logic       lz_blank;
    logic [3:0] nib;

    // Segment pattern {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Prescaler, digit index, frame-boundary shadow load and blink timing.
    always_comb begin
        tick     = (cnt_q == CNT_LAST);
        wrap     = tick && (d_q == 2'd3);
        cnt_d    = tick ? '0 : cnt_q + CW'(1);
        d_d      = tick ? d_q + 2'd1 : d_q;
        shadow_d = wrap ? hdata : shadow_q;
        fd_d     = wrap;
        fcnt_d   = fcnt_q;
        phase_d  = phase_q;
        if (!blink_en) begin
            fcnt_d  = '0;
            phase_d = PH_ON;
        end else if (wrap) begin
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d  = '0;
                phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    // Next anode/segment value from the current scan position and shadow.
    // blink_en is used directly so that dropping it overrides a stale off phase.
    always_comb begin
        slot_active = (cnt_q < CNT_ACTIVE);
        show_on     = !blink_en || (phase_q == PH_ON);
        case (d_q)
            2'd0: nib = shadow_q[3:0];
            2'd1: nib = shadow_q[7:4];
            2'd2: nib = shadow_q[11:8];
            default: nib = shadow_q[15:12];
        endcase
        case (d_q)
            2'd0: lz_blank = 1'b0;
            2'd1: lz_blank = blank_lz && (shadow_q[15:4] == '0);
            2'd2: lz_blank = blank_lz && (shadow_q[15:8] == '0);
            default: lz_blank = blank_lz && (shadow_q[15:12] == '0);
        endcase
        an_d  = '1;
        seg_d = '1;
        if (slot_active && show_on && !lz_blank) begin
            an_d  = ~(4'b0001 << d_q);
            seg_d = hex7(nib);
        end
    end

    // All state and registered outputs; reset aborts the scan immediately.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            d_q      <= '0;
            shadow_q <= '0;
            fcnt_q   <= '0;
            phase_q  <= PH_ON;
            an_q     <= '1;
            seg_q    <= '1;
            fd_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            d_q      <= d_d;
            shadow_q <= shadow_d;
            fcnt_q   <= fcnt_d;
            phase_q  <= phase_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            fd_q     <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = fd_q;

endmodule
